// File: rtl/net_traffic_endpoint_pkg.sv
// Shared net-message definitions for the traffic endpoint: field widths and positions,
// dest_mode and FSM encodings, and the 8-bit LFSR step (x^8+x^6+x^5+x^4+1).
package net_traffic_endpoint_pkg;

  localparam int NET_SRCDEST_NBITS = 3;
  localparam int NET_OPAQUE_NBITS  = 8;
  localparam int NET_PAYLOAD_NBITS = 32;

  localparam int NET_PAYLOAD_LSB = 0;
  localparam int NET_OPAQUE_LSB  = NET_PAYLOAD_LSB + NET_PAYLOAD_NBITS;
  localparam int NET_SRC_LSB     = NET_OPAQUE_LSB + NET_OPAQUE_NBITS;
  localparam int NET_DEST_LSB    = NET_SRC_LSB + NET_SRCDEST_NBITS;
  localparam int NET_MSG_NBITS   = NET_DEST_LSB + NET_SRCDEST_NBITS;

  typedef enum logic [1:0] {
    DEST_FIXED  = 2'd0,
    DEST_ROTATE = 2'd1,
    DEST_LFSR   = 2'd2,
    DEST_RSVD   = 2'd3
  } dest_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int net_msg_nbits(input int sd_nbits, input int op_nbits, input int pl_nbits);
    return 2 * sd_nbits + op_nbits + pl_nbits;
  endfunction

  // Fibonacci form, shifting left; taps at bits 7,5,4,3.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/net_traffic_lfsr.sv
// 8-bit LFSR with a parameterised seed; steps only when en is high.
module net_traffic_lfsr
  import net_traffic_endpoint_pkg::*;
#(
  parameter logic [7:0] p_seed = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] state
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= p_seed;
    end else if (en) begin
      state <= lfsr8_next(state);
    end
  end

endmodule

// File: rtl/net_traffic_endpoint.sv
// Network test endpoint: sends a programmed burst and checks/counts arrivals.
// Optional macro NET_TRAFFIC_ENDPOINT_RAND_DELAY_EN adds random send gaps and in_rdy stalls.
module net_traffic_endpoint
  import net_traffic_endpoint_pkg::*;
#(
  parameter int p_num_ports     = 4,
  parameter int p_payload_nbits = NET_PAYLOAD_NBITS,
  parameter int p_opaque_nbits  = NET_OPAQUE_NBITS,
  parameter int p_srcdest_nbits = NET_SRCDEST_NBITS,
  parameter int p_src_id        = 0,
  parameter int p_count_nbits   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       go,
  input  logic [p_count_nbits-1:0]   num_msgs,
  input  logic [p_count_nbits-1:0]   exp_recv,
  input  logic [1:0]                 dest_mode,
  input  logic [p_srcdest_nbits-1:0] fixed_dest,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [net_msg_nbits(p_srcdest_nbits, p_opaque_nbits, p_payload_nbits)-1:0] out_msg,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [net_msg_nbits(p_srcdest_nbits, p_opaque_nbits, p_payload_nbits)-1:0] in_msg,
  output logic                       done,
  output logic [p_count_nbits-1:0]   sent_count,
  output logic [p_count_nbits-1:0]   recv_count,
  output logic [p_count_nbits-1:0]   err_count,
  output logic                       error,
  output state_e                     dbg_state
);

  localparam int src_lsb  = p_payload_nbits + p_opaque_nbits;
  localparam int dest_lsb = src_lsb + p_srcdest_nbits;
  localparam logic [p_srcdest_nbits-1:0] src_id    = p_srcdest_nbits'(p_src_id);
  localparam logic [p_srcdest_nbits-1:0] last_port = p_srcdest_nbits'(p_num_ports - 1);
  localparam logic [p_srcdest_nbits-1:0] first_rot = p_srcdest_nbits'((p_src_id + 1) % p_num_ports);

  // Handshake: a transfer happens in a cycle where val && rdy at the rising edge;
  // the sender holds val and msg stable until that cycle.

  state_e                     state_q, state_d;
  logic                       start;
  logic                       send_ok;
  logic                       tx_fire, rx_fire, rx_bad;
  logic [p_count_nbits-1:0]   num_q, exp_q, seq_q;
  dest_mode_e                 mode_q;
  logic [p_srcdest_nbits-1:0] fixed_q, rot_q, tx_dest;
  logic [7:0]                 lfsr_q;
  logic                       rx_unused;

  function automatic logic [p_count_nbits-1:0] sat_inc(input logic [p_count_nbits-1:0] v);
    return (v == '1) ? v : v + p_count_nbits'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    out_val = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (go) begin
          start   = 1'b1;
          state_d = (num_msgs == '0) ? ST_DRAIN : ST_SEND;
        end
      end
      ST_SEND: begin
        out_val = send_ok;
        if (send_ok && out_rdy && (seq_q == num_q - p_count_nbits'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // >= so a burst that overshoots the expected count still finishes
        if (recv_count >= exp_q) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_fire   = out_val && out_rdy;
  assign rx_fire   = in_val && in_rdy;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_q      <= '0;
      exp_q      <= '0;
      mode_q     <= DEST_FIXED;
      fixed_q    <= '0;
      seq_q      <= '0;
      sent_count <= '0;
      recv_count <= '0;
      err_count  <= '0;
      error      <= 1'b0;
    end else if (start) begin
      num_q      <= num_msgs;
      exp_q      <= exp_recv;
      mode_q     <= dest_mode_e'(dest_mode);
      fixed_q    <= fixed_dest;
      seq_q      <= '0;
      sent_count <= '0;
      recv_count <= '0;
      err_count  <= '0;
      error      <= 1'b0;
    end else begin
      if (tx_fire) begin
        seq_q      <= seq_q + p_count_nbits'(1);
        sent_count <= sat_inc(sent_count);
      end
      if (rx_fire) begin
        recv_count <= sat_inc(recv_count);
        if (rx_bad) begin
          err_count <= sat_inc(err_count);
          error     <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rot_q <= first_rot;
    end else if (tx_fire) begin
      rot_q <= (rot_q == last_port) ? '0 : rot_q + p_srcdest_nbits'(1);
    end
  end

  net_traffic_lfsr #(.p_seed(8'h01)) u_dest_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (tx_fire),
    .state (lfsr_q)
  );

  always_comb begin
    tx_dest = fixed_q;
    case (mode_q)
      DEST_ROTATE: tx_dest = rot_q;
      DEST_LFSR:   tx_dest = p_srcdest_nbits'(lfsr_q & 8'(p_num_ports - 1));
      default:     tx_dest = fixed_q;
    endcase
  end

  assign out_msg = {tx_dest, src_id, p_opaque_nbits'(seq_q),
                    p_payload_nbits'({src_id, seq_q})};

  // The sender's id sits just above the sequence number in the payload.
  assign rx_bad = (in_msg[dest_lsb +: p_srcdest_nbits] != src_id) ||
                  (in_msg[p_count_nbits +: p_srcdest_nbits] != in_msg[src_lsb +: p_srcdest_nbits]);
  assign rx_unused = ^in_msg;

`ifdef NET_TRAFFIC_ENDPOINT_RAND_DELAY_EN
  logic [7:0] dly_q;
  logic [1:0] gap_q;
  logic       dly_unused;

  net_traffic_lfsr #(.p_seed(8'hA5)) u_delay_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .state (dly_q)
  );

  // A fresh gap is drawn whenever a new message becomes pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_q <= '0;
    end else if (start || tx_fire) begin
      gap_q <= dly_q[1:0];
    end else if (state_q == ST_SEND && gap_q != '0) begin
      gap_q <= gap_q - 2'd1;
    end
  end

  assign send_ok    = (gap_q == '0);
  assign in_rdy     = ~dly_q[2];
  assign dly_unused = ^dly_q[7:3];
`else
  assign send_ok = 1'b1;
  assign in_rdy  = 1'b1;
`endif

endmodule

// File: tb/tb_net_traffic_endpoint.sv
// Directed bench for net_traffic_endpoint: endpoint 0 (loopback, LFSR, misroute,
// zero-length, reset) and endpoint 1 (rotate) on a shared clock and reset.
module tb_net_traffic_endpoint;
  import net_traffic_endpoint_pkg::*;

  logic clk, reset;
  logic go0, go1;
  logic [15:0] num_msgs, exp_recv;
  logic [1:0]  dest_mode;
  logic [2:0]  fixed_dest;
  logic        out_rdy;
  logic        loop_en, inj_val;
  logic [NET_MSG_NBITS-1:0] inj_msg, held_msg;

  logic out_val0, in_rdy0, done0, error0, in_val0;
  logic [NET_MSG_NBITS-1:0] out_msg0, in_msg0;
  logic [15:0] sent0, recv0, err0;
  state_e st0;

  logic out_val1, in_rdy1, done1, error1;
  logic [NET_MSG_NBITS-1:0] out_msg1;
  logic [15:0] sent1, recv1, err1;
  state_e st1;

  int errors = 0;
  int checks = 0;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the "network" accepts a message only on a transmit fire and hands it straight back
  assign in_val0 = loop_en ? (out_val0 && out_rdy) : inj_val;
  assign in_msg0 = loop_en ? out_msg0 : inj_msg;

  net_traffic_endpoint #(.p_src_id(0)) dut0 (
    .clk(clk), .reset(reset), .go(go0), .num_msgs(num_msgs), .exp_recv(exp_recv),
    .dest_mode(dest_mode), .fixed_dest(fixed_dest), .out_val(out_val0), .out_rdy(out_rdy),
    .out_msg(out_msg0), .in_val(in_val0), .in_rdy(in_rdy0), .in_msg(in_msg0),
    .done(done0), .sent_count(sent0), .recv_count(recv0), .err_count(err0),
    .error(error0), .dbg_state(st0)
  );

  net_traffic_endpoint #(.p_src_id(1)) dut1 (
    .clk(clk), .reset(reset), .go(go1), .num_msgs(num_msgs), .exp_recv(exp_recv),
    .dest_mode(dest_mode), .fixed_dest(fixed_dest), .out_val(out_val1), .out_rdy(out_rdy),
    .out_msg(out_msg1), .in_val(1'b0), .in_rdy(in_rdy1), .in_msg('0),
    .done(done1), .sent_count(sent1), .recv_count(recv1), .err_count(err1),
    .error(error1), .dbg_state(st1)
  );

  // scoreboard helpers
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NET_MSG_NBITS-1:0] mk_msg(input logic [2:0] dest, input logic [2:0] src,
                                                      input logic [15:0] seq);
    return {dest, src, seq[7:0], 13'b0, src, seq};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input bit which, input logic [15:0] n, input logic [15:0] e,
                             input logic [1:0] mode, input logic [2:0] fd);
    num_msgs   = n;
    exp_recv   = e;
    dest_mode  = mode;
    fixed_dest = fd;
    if (which) go1 = 1'b1; else go0 = 1'b1;
    tick();
    go0 = 1'b0;
    go1 = 1'b0;
  endtask

  task automatic inject(input logic [NET_MSG_NBITS-1:0] m);
    inj_msg = m;
    inj_val = 1'b1;
    tick();
    inj_val = 1'b0;
  endtask

  logic [2:0] rot_exp [6];
  logic [2:0] lfsr_exp [3];

  initial begin
    reset = 1'b0; go0 = 1'b0; go1 = 1'b0; num_msgs = '0; exp_recv = '0;
    dest_mode = 2'd0; fixed_dest = 3'd0; out_rdy = 1'b1; loop_en = 1'b0;
    inj_val = 1'b0; inj_msg = '0;
    rot_exp  = '{3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
    lfsr_exp = '{3'd1, 3'd2, 3'd0};

    // reset values
    repeat (2) tick();
    chk("rst_out_val", 64'(out_val0), 64'(0));
    chk("rst_in_rdy", 64'(in_rdy0), 64'(1));
    chk("rst_done", 64'(done0), 64'(0));
    chk("rst_error", 64'(error0), 64'(0));
    chk("rst_counts", 64'({sent0, recv0, err0}), 64'(0));
    chk("rst_state", 64'(st0), 64'(ST_IDLE));
    reset = 1'b1;
    tick();

    // LFSR destinations from seed 01: 01 -> 02 -> 04
    start_burst(1'b0, 16'd3, 16'd0, 2'd2, 3'd0);
    for (int k = 0; k < 3; k++) begin
      chk("lfsr_val", 64'(out_val0), 64'(1));
      chk("lfsr_msg", 64'(out_msg0), 64'(mk_msg(lfsr_exp[k], 3'd0, 16'(k))));
      tick();
    end
    chk("lfsr_drain", 64'(st0), 64'(ST_DRAIN));
    tick();
    chk("lfsr_done", 64'(done0), 64'(1));
    chk("lfsr_sent", 64'(sent0), 64'(3));

    // fixed dest loopback, 5 messages
    loop_en = 1'b1;
    start_burst(1'b0, 16'd5, 16'd5, 2'd0, 3'd0);
    chk("lb_cleared", 64'(sent0), 64'(0));
    for (int k = 0; k < 5; k++) begin
      chk("lb_msg", 64'(out_msg0), 64'(mk_msg(3'd0, 3'd0, 16'(k))));
      tick();
    end
    chk("lb_drain", 64'(st0), 64'(ST_DRAIN));
    chk("lb_not_done", 64'(done0), 64'(0));
    chk("lb_sent", 64'(sent0), 64'(5));
    chk("lb_recv", 64'(recv0), 64'(5));
    tick();
    chk("lb_done", 64'(done0), 64'(1));
    chk("lb_err", 64'(err0), 64'(0));

    // backpressure: 4 stalled cycles after two fires
    start_burst(1'b0, 16'd6, 16'd6, 2'd0, 3'd0);
    for (int k = 0; k < 2; k++) begin
      chk("bp_msg", 64'(out_msg0), 64'(mk_msg(3'd0, 3'd0, 16'(k))));
      tick();
    end
    out_rdy  = 1'b0;
    held_msg = out_msg0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_hold_val", 64'(out_val0), 64'(1));
      chk("bp_hold_msg", 64'(out_msg0), 64'(held_msg));
    end
    chk("bp_stall_sent", 64'(sent0), 64'(2));
    out_rdy = 1'b1;
    for (int k = 2; k < 6; k++) begin
      chk("bp_msg", 64'(out_msg0), 64'(mk_msg(3'd0, 3'd0, 16'(k))));
      tick();
    end
    chk("bp_sent", 64'(sent0), 64'(6));
    chk("bp_recv", 64'(recv0), 64'(6));
    tick();
    chk("bp_done", 64'(done0), 64'(1));

    // receive checks while sitting in DONE
    loop_en = 1'b0;
    inject(mk_msg(3'd2, 3'd0, 16'd0));
    chk("mis_recv", 64'(recv0), 64'(7));
    chk("mis_err", 64'(err0), 64'(1));
    chk("mis_error", 64'(error0), 64'(1));
    inject(mk_msg(3'd0, 3'd0, 16'd9));
    chk("good_recv", 64'(recv0), 64'(8));
    chk("good_err", 64'(err0), 64'(1));
    inject({3'd0, 3'd3, 8'd0, 32'd0});
    chk("plsrc_err", 64'(err0), 64'(2));
    chk("plsrc_recv", 64'(recv0), 64'(9));
    chk("mis_state", 64'(st0), 64'(ST_DONE));

    // zero-length burst
    start_burst(1'b0, 16'd0, 16'd0, 2'd0, 3'd0);
    chk("zero_state", 64'(st0), 64'(ST_DRAIN));
    chk("zero_val", 64'(out_val0), 64'(0));
    chk("zero_done1", 64'(done0), 64'(0));
    chk("zero_clear", 64'({error0, err0, recv0}), 64'(0));
    tick();
    chk("zero_done2", 64'(done0), 64'(1));
    chk("zero_val2", 64'(out_val0), 64'(0));

    // rotate on endpoint 1 starts at port 2
    start_burst(1'b1, 16'd6, 16'd0, 2'd1, 3'd0);
    for (int k = 0; k < 6; k++) begin
      chk("rot_msg", 64'(out_msg1), 64'(mk_msg(rot_exp[k], 3'd1, 16'(k))));
      tick();
    end
    tick();
    chk("rot_done", 64'(done1), 64'(1));
    chk("rot_sent", 64'(sent1), 64'(6));

    // reset in the middle of a burst
    loop_en = 1'b1;
    start_burst(1'b0, 16'd8, 16'd8, 2'd0, 3'd0);
    repeat (3) tick();
    chk("mid_sent", 64'(sent0), 64'(3));
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_val", 64'(out_val0), 64'(0));
    chk("mid_rst_counts", 64'({sent0, recv0, err0}), 64'(0));
    chk("mid_rst_state", 64'(st0), 64'(ST_IDLE));
    chk("mid_rst_in_rdy", 64'(in_rdy0), 64'(1));
    tick();
    reset = 1'b1;
    tick();
    start_burst(1'b0, 16'd2, 16'd2, 2'd0, 3'd0);
    for (int k = 0; k < 2; k++) begin
      chk("restart_msg", 64'(out_msg0), 64'(mk_msg(3'd0, 3'd0, 16'(k))));
      tick();
    end
    tick();
    chk("restart_done", 64'(done0), 64'(1));
    chk("restart_counts", 64'({sent0, recv0}), 64'({16'd2, 16'd2}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
